// File: rtl/softusb_navre_ctl.sv
// Run controller for the navre AVR core: loads pmem from host commands, gates core reset,
// and detects the end-of-program I/O marker. Define SOFTUSB_NAVRE_WDT_EN to add a cycle-limit watchdog.
module softusb_navre_ctl #(
  parameter int unsigned WDT_CYCLES = 10000,
  parameter int unsigned WDT_W      = 14,
  parameter logic [5:0]  DONE_ADR   = 6'h00,
  parameter logic [7:0]  DONE_DAT   = 8'hFE
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_stb,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_adr,
  input  logic [15:0] cmd_dat,
  output logic        cmd_ack,
  output logic        cmd_err,
  output logic        pmem_we,
  output logic [9:0]  pmem_wa,
  output logic [15:0] pmem_wd,
  output logic        core_rst,
  input  logic        io_we,
  input  logic [5:0]  io_a,
  input  logic [7:0]  io_do,
  output logic        running,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t state, state_nx;
  logic   ack_nx, err_nx, we_nx;
  logic   done_hit, wdt_expire;

  if ((64'd1 << WDT_W) <= 64'(WDT_CYCLES)) begin : g_wdt_w_check
    $error("WDT_W too narrow to hold WDT_CYCLES");
  end

  assign done_hit = (state == S_RUN) && io_we && (io_a == DONE_ADR) && (io_do == DONE_DAT);

`ifdef SOFTUSB_NAVRE_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_expire = (state == S_RUN) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
  assign timeout    = (state == S_TIMEOUT);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      wdt_cnt <= '0;
    else if (state != S_RUN && state_nx == S_RUN)
      wdt_cnt <= '0;
    else if (state == S_RUN && wdt_cnt != '1)
      wdt_cnt <= wdt_cnt + WDT_W'(1);
  end
`else
  assign wdt_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Done marker outranks watchdog expiry, which outranks any host command;
  // a command that loses simply stays pending and is re-evaluated next edge.
  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    we_nx    = 1'b0;
    if (done_hit) begin
      state_nx = S_DONE;
    end else if (wdt_expire) begin
      state_nx = S_TIMEOUT;
    end else if (cmd_stb) begin
      ack_nx = 1'b1;
      case (cmd_op)
        2'd0: begin
          if (state == S_RUN) err_nx = 1'b1;
          else                we_nx  = 1'b1;
        end
        2'd1: begin
          if (state == S_RUN) err_nx   = 1'b1;
          else                state_nx = S_RUN;
        end
        2'd2:    state_nx = S_IDLE;
        default: err_nx   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      pmem_we <= 1'b0;
      pmem_wa <= '0;
      pmem_wd <= '0;
    end else begin
      state   <= state_nx;
      cmd_ack <= ack_nx;
      cmd_err <= err_nx;
      pmem_we <= we_nx;
      if (we_nx) begin
        pmem_wa <= cmd_adr;
        pmem_wd <= cmd_dat;
      end
    end
  end

  assign core_rst = (state != S_RUN);
  assign running  = (state == S_RUN);
  assign done     = (state == S_DONE);

endmodule

// File: doc/softusb_navre_ctl.md
# softusb_navre_ctl

Run controller for the navre AVR core. It owns the core's reset and the host-side write port of the 1024x16 program memory. It loads firmware words from a host command port, releases the core, snoops core I/O writes for the end-of-program marker, and optionally enforces a cycle-limit watchdog. It sits between the host/CSR interface and the `softusb_navre` core plus its pmem.

## Interface
Parameters:
- `WDT_CYCLES`, 10000: maximum RUN cycles before forced stop.
- `WDT_W`, 14: watchdog counter width; must satisfy 2^WDT_W > WDT_CYCLES.
- `DONE_ADR`, 6'h00: I/O address of the end-of-program marker.
- `DONE_DAT`, 8'hFE: I/O data value of the end-of-program marker.

Ports:
- `sys_clk`  in  1  system clock, all logic on the rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `cmd_stb`  in  1  command request; held high until `cmd_ack`.
- `cmd_op`  in  2  command: 0 LOAD, 1 RUN, 2 HALT, 3 reserved.
- `cmd_adr`  in  10  LOAD word address.
- `cmd_dat`  in  16  LOAD word data.
- `cmd_ack`  out  1  one-cycle pulse completing the command.
- `cmd_err`  out  1  pulses with `cmd_ack` when the command is rejected.
- `pmem_we`  out  1  pmem write strobe.
- `pmem_wa`  out  10  pmem write address.
- `pmem_wd`  out  16  pmem write data.
- `core_rst`  out  1  reset to the navre core.
- `io_we`  in  1  core I/O write strobe (snooped).
- `io_a`  in  6  core I/O address.
- `io_do`  in  8  core I/O write data.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  high in TIMEOUT.

## Operation
- States: IDLE, RUN, DONE, TIMEOUT. `core_rst` = 1 in every state except RUN.
- Reset: state IDLE. `core_rst`=1, `pmem_we`=0, `pmem_wa`=0, `pmem_wd`=0, `cmd_ack`=0, `cmd_err`=0, `running`/`done`/`timeout`=0, watchdog=0.
- LOAD in IDLE, DONE or TIMEOUT: performs a one-cycle pmem write of `cmd_dat` at `cmd_adr`. State is unchanged. The `done` and `timeout` flags persist.
- LOAD in RUN: rejected with `cmd_err`. No write occurs.
- RUN in any non-RUN state: goes to RUN. Clears `done`/`timeout` and clears the watchdog. The core always restarts from address 0 via its reset.
- RUN in RUN: rejected with `cmd_err`.
- HALT: from any state goes to IDLE, clearing `done`/`timeout`. Never rejected.
- Reserved op: acked with `cmd_err`. No other effect.
- Done detection, only in RUN: `io_we & (io_a==DONE_ADR) & (io_do==DONE_DAT)` goes to DONE. The same match outside RUN is ignored.
- Commands are not queued; one command is in flight at a time.

## Timing
- `cmd_stb` is sampled at edge N. `cmd_ack` and `cmd_err` are high during cycle N+1 only.
- A LOAD sampled at edge N drives `pmem_we`=1 with registered `pmem_wa`/`pmem_wd` during cycle N+1, the same cycle as `cmd_ack`.
- The host must drop `cmd_stb` or present a new command in cycle N+1. A `cmd_stb` high again at edge N+1 is a new command.
- RUN sampled at N: `core_rst`=0 and `running`=1 from cycle N+1.
- HALT sampled at N: `core_rst`=1 from cycle N+1.
- Done match sampled at edge M: `core_rst`=1 and `done`=1 from cycle M+1.
- Simultaneous events at the same edge: done match beats watchdog expiry, which beats any command.
  - A command losing arbitration gets no ack that cycle.
  - It is evaluated against the new state at the next edge while `cmd_stb` remains high.
- Asynchronous reset mid-LOAD or mid-RUN: returns to IDLE immediately. The pending command is dropped without ack.

## Configuration
- `SOFTUSB_NAVRE_WDT_EN` defined:
  - The watchdog counts edges spent in RUN, starting at 0 on entry.
  - When the count reaches WDT_CYCLES-1 in RUN, the next state is TIMEOUT. The core has therefore run exactly WDT_CYCLES cycles with `core_rst`=0.
  - In TIMEOUT, `timeout`=1 and `core_rst`=1.
  - The counter saturates and never wraps.
- Not defined: no counter logic. TIMEOUT is unreachable, `timeout` is tied 0, and RUN lasts until a done match or HALT.

## Test plan
- Reset then LOAD adr=0x3FF dat=0xBEEF → `pmem_we`=1, `pmem_wa`=0x3FF, `pmem_wd`=0xBEEF one cycle after the strobe, with `cmd_ack`=1 and `cmd_err`=0 in that cycle.
- RUN, then io write a=0x00 d=0xFE at edge M → `core_rst`=1 and `done`=1 at cycle M+1. A write of a=0x00 d=0xFD leaves the block in RUN.
- LOAD issued while RUN → `cmd_ack`=1, `cmd_err`=1, `pmem_we` stays 0, `running` stays 1.
- With WDT_EN and WDT_CYCLES=16, RUN with no marker → `core_rst` low for exactly 16 cycles, then `timeout`=1. A subsequent RUN clears `timeout` and restarts.
- Done match and watchdog expiry at the same edge, and also with `cmd_stb` HALT pending → state DONE, no ack. HALT is acked one cycle later and the block enters IDLE.
- Assert `sys_rst` asynchronously mid-RUN, between clock edges → `core_rst`=1 and all flags 0 immediately, with no `cmd_ack` for the pending command.
